output_argmax: RTL and testbench
================================

OUTPUT_ARGMAX -- requirements
Module: OutputArgmax

Interface
REQ-001 SHALL have parameter NO, default 2: number of output neurons per vector.
REQ-002 SHALL have parameter WO, default 11: signed two's-complement width of one output element.
REQ-003 SHALL have parameter WC, default 16: width of the statistics counters.
REQ-004 SHALL define the derived width WI = (NO>1 ? $clog2(NO) : 1) for class indices.
REQ-005 SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port iRST, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports iValid_AM_Output (in, 1), oReady_AM_Output (out, 1) and iData_AM_Output (in, NO*WO): the output-vector stream; element k occupies bits [k*WO +: WO].
REQ-008 SHALL have ports iValid_AM_Label (in, 1), oReady_AM_Label (out, 1) and iData_AM_Label (in, WI): the expected class index stream.
REQ-009 SHALL have ports oValid_BM_Result (out, 1), iReady_BM_Result (in, 1) and oData_BM_Result (out, WI+1): result, {index, hit}, with hit as the LSB.
REQ-010 SHALL have port iClear, input, 1 bit: synchronous clear of both counters.
REQ-011 SHALL have ports oCount_Total (out, WC) and oCount_Hit (out, WC): the number of results delivered and the number of those with hit=1.

Function
REQ-012 SHALL treat each stream as valid/ready: a transfer occurs on a rising edge with valid=1 and ready=1; ready SHALL NOT depend combinationally on the same-port valid.
REQ-013 SHALL implement the FSM states LOAD, SCAN and EMIT.
REQ-014 In LOAD, SHALL drive oReady_AM_Output = !haveO and oReady_AM_Label = !haveL, and set haveO or haveL on the corresponding transfer, registering the data.
REQ-015 SHALL accept the two streams independently, in either order or in the same cycle.
REQ-016 When both have-flags are set, SHALL load max = element 0 and idx = 0, then go to SCAN if NO>1, otherwise go to EMIT.
REQ-017 In SCAN, SHALL examine element k (k = 1..NO-1) in cycle k and replace max and idx only when element k > max under a signed comparison; on a tie the lower index is kept.
REQ-018 After the element NO-1 compare, SHALL go to EMIT; latency from entering SCAN to oValid_BM_Result = NO-1 cycles.
REQ-019 In EMIT, SHALL drive oValid_BM_Result = 1 and oData_BM_Result = {idx, (idx == label)}.
REQ-020 SHALL set hit = 0 when the label is >= NO.
REQ-021 SHALL hold oValid_BM_Result and oData_BM_Result stable until iReady_BM_Result = 1.
REQ-022 On the result transfer, SHALL increment oCount_Total, increment oCount_Hit if hit = 1, clear both have-flags and return to LOAD.
REQ-023 Both readys SHALL be 0 in SCAN and EMIT.
REQ-024 Counters SHALL saturate at all-ones and never wrap.
REQ-025 iClear = 1 SHALL set both counters to 0 on the next edge; if this coincides with a result transfer, the clear wins and that result is not counted; the FSM is unaffected by iClear.
REQ-026 SHALL sustain at most one vector per NO+1 cycles; no input buffering beyond one vector and one label is required.

Reset
REQ-027 With iRST = 0, SHALL immediately, without waiting for a clock edge, enter LOAD with haveO = haveL = 0, oValid_BM_Result = 0, and oData_BM_Result, max, idx, oCount_Total and oCount_Hit all = 0.
REQ-028 Reset asserted during SCAN or EMIT SHALL discard the vector in flight, and no result for it SHALL appear after reset release.
REQ-029 oReady_AM_Output and oReady_AM_Label SHALL be 1 in the first cycle after reset release.

Verification
REQ-030 NO=2, WO=11: Output {e1=0x005, e0=0x003} with label 1 -> result {1,1} one cycle after SCAN is entered; Total=1, Hit=1.
REQ-031 Tie and signed cases: e0 = e1 = 0x010 with label 1 -> {0,0}; e0 = 0x7FF (-1), e1 = 0x001 with label 1 -> {1,1}.
REQ-032 Skew and backpressure: label first, output 5 cycles later, iReady_BM_Result held 0 for 4 cycles -> result data stable throughout and both readys 0; counted exactly once.
REQ-033 Reset is pulsed low during SCAN with NO=4 -> outputs return to reset values asynchronously, no result is emitted, and the next vector processes normally.
REQ-034 WC=2: after 5 hit results -> Total = Hit = 3 (saturated); iClear coincident with the 6th transfer -> Total = Hit = 0.

Source files
------------

// File: rtl/output_argmax.sv
// output_argmax: registers one output vector and one label, finds the index of
// the largest signed element, and reports {index, hit} plus running counters.
// Latency: one load cycle after both inputs are held, then NO-1 scan cycles to
// a valid result. Backpressure: result held until iReady_BM_Result; both input
// readys stay low until the result is taken.
// Ports: iCLK/iRST clock and async active-low reset; *_AM_Output vector stream
// (NO x WO packed, element k at [k*WO +: WO]); *_AM_Label class stream;
// *_BM_Result {idx, hit} stream; iClear zeroes the counters; oCount_* stats.
module output_argmax #(
  parameter  int NO = 2,
  parameter  int WO = 11,
  parameter  int WC = 16,
  localparam int WI = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM_Output,
  output logic             oReady_AM_Output,
  input  logic [NO*WO-1:0] iData_AM_Output,
  input  logic             iValid_AM_Label,
  output logic             oReady_AM_Label,
  input  logic [WI-1:0]    iData_AM_Label,
  output logic             oValid_BM_Result,
  input  logic             iReady_BM_Result,
  output logic [WI:0]      oData_BM_Result,
  input  logic             iClear,
  output logic [WC-1:0]    oCount_Total,
  output logic [WC-1:0]    oCount_Hit
);

  typedef enum logic [1:0] {LOAD = 2'd0, SCAN = 2'd1, EMIT = 2'd2} state_t;

  state_t               state_q;
  logic                 have_o_q;
  logic                 have_l_q;
  logic [NO*WO-1:0]     vec_q;
  logic [WI-1:0]        lab_q;
  logic [WI-1:0]        idx_q;
  logic [WI-1:0]        k_q;
  logic signed [WO-1:0] max_q;
  logic                 valid_q;
  logic [WI:0]          data_q;
  logic [WC-1:0]        total_q;
  logic [WC-1:0]        hit_q;

  logic                 xfer_o;
  logic                 xfer_l;
  logic                 xfer_r;
  logic signed [WO-1:0] elem_k;
  logic                 gt;
  logic [WI-1:0]        idx_d;
  logic                 last_k;

  // Readys depend only on state, never on the incoming valid.
  assign oReady_AM_Output = (state_q == LOAD) && !have_o_q;
  assign oReady_AM_Label  = (state_q == LOAD) && !have_l_q;

  assign xfer_o = iValid_AM_Output && oReady_AM_Output;
  assign xfer_l = iValid_AM_Label && oReady_AM_Label;
  assign xfer_r = valid_q && iReady_BM_Result;

  // Strict greater-than keeps the lower index on a tie.
  assign elem_k = vec_q[int'(k_q)*WO +: WO];
  assign gt     = elem_k > max_q;
  assign idx_d  = gt ? k_q : idx_q;
  assign last_k = (k_q == WI'(NO - 1));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= LOAD;
      have_o_q <= 1'b0;
      have_l_q <= 1'b0;
      vec_q    <= '0;
      lab_q    <= '0;
      idx_q    <= '0;
      k_q      <= '0;
      max_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      total_q  <= '0;
      hit_q    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer_o) begin
            vec_q    <= iData_AM_Output;
            have_o_q <= 1'b1;
          end
          if (xfer_l) begin
            lab_q    <= iData_AM_Label;
            have_l_q <= 1'b1;
          end
          if (have_o_q && have_l_q) begin
            max_q <= vec_q[WO-1:0];
            idx_q <= '0;
            k_q   <= WI'(1);
            if (NO > 1) begin
              state_q <= SCAN;
            end else begin
              state_q <= EMIT;
              valid_q <= 1'b1;
              data_q  <= {{WI{1'b0}}, (lab_q == '0)};
            end
          end
        end
        SCAN: begin
          if (gt) max_q <= elem_k;
          idx_q <= idx_d;
          k_q   <= k_q + WI'(1);
          if (last_k) begin
            state_q <= EMIT;
            valid_q <= 1'b1;
            // idx is always < NO, so an out-of-range label can never match.
            data_q  <= {idx_d, (lab_q == idx_d)};
          end
        end
        EMIT: begin
          if (iReady_BM_Result) begin
            valid_q  <= 1'b0;
            have_o_q <= 1'b0;
            have_l_q <= 1'b0;
            state_q  <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase

      // Clear has priority: a result taken in the same cycle is not counted.
      if (iClear) begin
        total_q <= '0;
        hit_q   <= '0;
      end else if (xfer_r) begin
        if (total_q != '1) total_q <= total_q + WC'(1);
        if (data_q[0] && (hit_q != '1)) hit_q <= hit_q + WC'(1);
      end
    end
  end

  assign oValid_BM_Result = valid_q;
  assign oData_BM_Result  = data_q;
  assign oCount_Total     = total_q;
  assign oCount_Hit       = hit_q;

endmodule

// File: tb/tb_output_argmax.sv
// tb_output_argmax: directed bench for output_argmax using two instances,
// A (NO=2, WO=11, WC=16) and B (NO=4, WO=11, WC=2), with a per-instance
// expected-result queue and hand-derived expected counter values.
module tb_output_argmax;

  logic clk;
  logic rst_n;

  // Instance A signals
  logic        a_ov, a_or, a_lv, a_lr, a_rv, a_rr, a_clr;
  logic [21:0] a_od;
  logic [0:0]  a_ld;
  logic [1:0]  a_rd;
  logic [15:0] a_tot, a_hit;

  // Instance B signals
  logic        b_ov, b_or, b_lv, b_lr, b_rv, b_rr, b_clr;
  logic [43:0] b_od;
  logic [1:0]  b_ld;
  logic [2:0]  b_rd;
  logic [1:0]  b_tot, b_hit;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] a_q[$];
  logic [2:0] b_q[$];
  int a_et = 0, a_eh = 0, b_et = 0, b_eh = 0;
  int lat;

  // B stimulus rows: elements e0..e3 and the hand-derived argmax index.
  logic [10:0] b_tab [6][4];
  int          b_ix  [6];

  output_argmax #(.NO(2), .WO(11), .WC(16)) u_a (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AM_Output(a_ov), .oReady_AM_Output(a_or), .iData_AM_Output(a_od),
    .iValid_AM_Label(a_lv), .oReady_AM_Label(a_lr), .iData_AM_Label(a_ld),
    .oValid_BM_Result(a_rv), .iReady_BM_Result(a_rr), .oData_BM_Result(a_rd),
    .iClear(a_clr), .oCount_Total(a_tot), .oCount_Hit(a_hit)
  );

  output_argmax #(.NO(4), .WO(11), .WC(2)) u_b (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AM_Output(b_ov), .oReady_AM_Output(b_or), .iData_AM_Output(b_od),
    .iValid_AM_Label(b_lv), .oReady_AM_Label(b_lr), .iData_AM_Label(b_ld),
    .oValid_BM_Result(b_rv), .iReady_BM_Result(b_rr), .oData_BM_Result(b_rd),
    .iClear(b_clr), .oCount_Total(b_tot), .oCount_Hit(b_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // skew > 0: label first, output skew cycles later; skew < 0: the reverse.
  task automatic a_send(input logic [10:0] e0, input logic [10:0] e1, input logic lab,
                        input int skew, input logic [1:0] exp);
    int mag;
    mag = (skew > 0) ? skew : -skew;
    a_q.push_back(exp);
    if (skew >= 0) begin a_lv = 1'b1; a_ld = lab; end
    if (skew <= 0) begin a_ov = 1'b1; a_od = {e1, e0}; end
    @(negedge clk);
    a_lv = 1'b0;
    a_ov = 1'b0;
    if (skew != 0) begin
      for (int i = 1; i < mag; i++) begin
        chk("a_skew_rdy", 32'({a_or, a_lr}), (skew > 0) ? 32'd2 : 32'd1);
        @(negedge clk);
      end
      chk("a_skew_rdy", 32'({a_or, a_lr}), (skew > 0) ? 32'd2 : 32'd1);
      if (skew > 0) begin a_ov = 1'b1; a_od = {e1, e0}; end
      else begin a_lv = 1'b1; a_ld = lab; end
      @(negedge clk);
      a_lv = 1'b0;
      a_ov = 1'b0;
    end
  endtask

  task automatic a_result(input int hold, output int l);
    logic [1:0] exp;
    l = 0;
    while (!a_rv && l < 50) begin
      chk("a_busy_rdy", 32'({a_or, a_lr}), 32'd0);
      @(negedge clk);
      l++;
    end
    chk("a_valid", 32'(a_rv), 32'd1);
    chk("a_sb_nonempty", 32'(a_q.size() != 0), 32'd1);
    exp = (a_q.size() != 0) ? a_q.pop_front() : 2'b00;
    for (int i = 0; i < hold; i++) begin
      chk("a_hold_data", 32'(a_rd), 32'(exp));
      chk("a_hold_valid", 32'(a_rv), 32'd1);
      chk("a_hold_rdy", 32'({a_or, a_lr}), 32'd0);
      @(negedge clk);
    end
    a_rr = 1'b1;
    chk("a_data", 32'(a_rd), 32'(exp));
    @(negedge clk);
    a_rr = 1'b0;
    chk("a_valid_drop", 32'(a_rv), 32'd0);
  endtask

  task automatic a_counts();
    chk("a_total", 32'(a_tot), 32'(a_et));
    chk("a_hits", 32'(a_hit), 32'(a_eh));
  endtask

  task automatic b_send(input int row, input logic [1:0] lab);
    logic [1:0] ix;
    ix = 2'(b_ix[row]);
    b_q.push_back({ix, (lab == ix)});
    b_ov = 1'b1;
    b_od = {b_tab[row][3], b_tab[row][2], b_tab[row][1], b_tab[row][0]};
    b_lv = 1'b1;
    b_ld = lab;
    @(negedge clk);
    b_ov = 1'b0;
    b_lv = 1'b0;
  endtask

  task automatic b_result(input logic clr, output int l);
    logic [2:0] exp;
    l = 0;
    while (!b_rv && l < 50) begin
      @(negedge clk);
      l++;
    end
    chk("b_valid", 32'(b_rv), 32'd1);
    chk("b_sb_nonempty", 32'(b_q.size() != 0), 32'd1);
    exp = (b_q.size() != 0) ? b_q.pop_front() : 3'b000;
    b_rr  = 1'b1;
    b_clr = clr;
    chk("b_data", 32'(b_rd), 32'(exp));
    @(negedge clk);
    b_rr  = 1'b0;
    b_clr = 1'b0;
    chk("b_valid_drop", 32'(b_rv), 32'd0);
  endtask

  task automatic b_counts();
    chk("b_total", 32'(b_tot), 32'(b_et));
    chk("b_hits", 32'(b_hit), 32'(b_eh));
  endtask

  initial begin
    b_tab = '{'{11'h001, 11'h005, 11'h020, 11'h010},
              '{11'h7F0, 11'h7F8, 11'h400, 11'h7FC},
              '{11'h007, 11'h009, 11'h003, 11'h009},
              '{11'h3FF, 11'h3FF, 11'h3FF, 11'h3FF},
              '{11'h400, 11'h401, 11'h7FF, 11'h000},
              '{11'h002, 11'h001, 11'h000, 11'h7FF}};
    b_ix  = '{2, 3, 1, 0, 3, 0};

    a_ov = 0; a_lv = 0; a_rr = 0; a_clr = 0; a_od = '0; a_ld = '0;
    b_ov = 0; b_lv = 0; b_rr = 0; b_clr = 0; b_od = '0; b_ld = '0;
    rst_n = 1'b0;

    // Reset values while reset is held
    #12;
    chk("rst_a_valid", 32'(a_rv), 32'd0);
    chk("rst_a_data", 32'(a_rd), 32'd0);
    a_counts();
    chk("rst_b_valid", 32'(b_rv), 32'd0);
    chk("rst_b_data", 32'(b_rd), 32'd0);
    b_counts();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_a_rdy", 32'({a_or, a_lr}), 32'd3);
    chk("rel_b_rdy", 32'({b_or, b_lr}), 32'd3);
    @(negedge clk);

    // A: basic argmax, valid one cycle after SCAN entry
    a_send(11'h003, 11'h005, 1'b1, 0, 2'b11);
    a_result(0, lat);
    chk("a_latency", 32'(lat), 32'd2);
    a_et = 1; a_eh = 1; a_counts();

    // A: tie keeps index 0, label 1 misses
    a_send(11'h010, 11'h010, 1'b1, 0, 2'b00);
    a_result(0, lat);
    a_et = 2; a_counts();

    // A: e0 = -1 loses to e1 = +1
    a_send(11'h7FF, 11'h001, 1'b1, 0, 2'b11);
    a_result(0, lat);
    a_et = 3; a_eh = 2; a_counts();

    // A: label 5 cycles ahead of output, 4 cycles of result backpressure
    a_send(11'h100, 11'h0FF, 1'b0, 5, 2'b01);
    a_result(4, lat);
    a_et = 4; a_eh = 3; a_counts();

    // A: signed compare, +1 beats -1
    a_send(11'h001, 11'h7FF, 1'b0, 0, 2'b01);
    a_result(0, lat);
    a_et = 5; a_eh = 4; a_counts();

    // A: output 3 cycles ahead of label
    a_send(11'h200, 11'h300, 1'b0, -3, 2'b10);
    a_result(2, lat);
    a_et = 6; a_counts();

    // A: clear without a result transfer
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    a_et = 0; a_eh = 0; a_counts();

    // B: max at index 2, label 0 misses
    b_send(0, 2'd0);
    b_result(1'b0, lat);
    chk("b_latency", 32'(lat), 32'd4);
    b_et = 1; b_eh = 0; b_counts();

    // B: reset pulsed while scanning; vector dropped, outputs clear at once
    b_send(1, 2'd3);
    @(negedge clk);
    chk("b_scan_no_valid", 32'(b_rv), 32'd0);
    chk("b_scan_rdy", 32'({b_or, b_lr}), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_b_valid", 32'(b_rv), 32'd0);
    chk("async_b_data", 32'(b_rd), 32'd0);
    chk("async_b_total", 32'(b_tot), 32'd0);
    chk("async_b_rdy", 32'({b_or, b_lr}), 32'd3);
    b_q.delete();
    a_q.delete();
    b_et = 0; b_eh = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_b_rdy", 32'({b_or, b_lr}), 32'd3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b_no_stale_result", 32'(b_rv), 32'd0);
    end

    // B: five hits after reset; the 2-bit counters stop at 3
    for (int r = 1; r <= 5; r++) begin
      b_send(r, 2'(b_ix[r]));
      b_result(1'b0, lat);
      if (r == 1) chk("b_latency_post_rst", 32'(lat), 32'd4);
      if (b_et < 3) b_et++;
      if (b_eh < 3) b_eh++;
      b_counts();
    end

    // B: clear coincides with a hit transfer; clear wins
    b_send(0, 2'd2);
    b_result(1'b1, lat);
    b_et = 0; b_eh = 0; b_counts();

    // B: processing continues normally after the clear
    b_send(2, 2'd1);
    b_result(1'b0, lat);
    b_et = 1; b_eh = 1; b_counts();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
